// File: rtl/decoder_pkg.sv
// Shared types and constants for the registered one-hot decoder with scan mode.
package decoder_pkg;

    // Operating state of the decoder controller.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_e;

    // Encoding of the mode input.
    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/decoder_scan_onehot_dec.sv
// Combinational SEL_W -> 2**SEL_W one-hot decoder with an enable that forces all-zero.
module onehot_dec #(
    parameter int SEL_W = 2
) (
    input  logic                  en_i,
    input  logic [SEL_W-1:0]      sel_i,
    output logic [2**SEL_W-1:0]   y_o
);

    // Drive exactly one line high for the selected index, or none when disabled.
    always_comb begin
        y_o = '0;
        if (en_i) begin
            y_o[sel_i] = 1'b1;
        end
    end

endmodule

// File: rtl/decoder_scan.sv
// Registered one-hot decoder with DIRECT (handshaked index) and SCAN (auto-cycling
// with programmable dwell) modes. All outputs except sel_ready come from flops so
// downstream line enables never see decode glitches.
module decoder_scan
    import decoder_pkg::*;
#(
    parameter int SEL_W = 2,
    parameter int DWELL = 4,
    parameter int CNT_W = $clog2(DWELL + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel_in,
    input  logic                  sel_valid,
    output logic                  sel_ready,
    output logic [2**SEL_W-1:0]   y,
    output logic                  y_valid,
    output logic                  scan_wrap
);

    localparam int                N          = 2**SEL_W;
    localparam logic [SEL_W-1:0]  IDX_LAST   = '1;
    localparam logic [CNT_W-1:0]  DWELL_LAST = CNT_W'(DWELL - 1);

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    dwell_q, dwell_d;
    logic [N-1:0]        y_q, dec_y;
    logic                y_valid_q;
    logic                wrap_q, wrap_d;
    logic                accept;

    // Only accept an index once DIRECT is settled and the inputs still ask for DIRECT,
    // so a mode switch or enable drop on the same cycle never captures sel_in.
    always_comb begin
        sel_ready = enable && (mode == MODE_DIRECT) && (state_q == DIRECT);
        accept    = sel_ready && sel_valid;
    end

    // Next state follows enable/mode directly; index and dwell counter update per state.
    always_comb begin
        state_d = IDLE;
        if (enable) begin
            state_d = (mode == MODE_SCAN) ? SCAN : DIRECT;
        end

        idx_d   = idx_q;
        dwell_d = dwell_q;
        wrap_d  = 1'b0;

        case (state_d)
            IDLE: begin
                idx_d   = idx_q;
                dwell_d = dwell_q;
            end
            DIRECT: begin
                dwell_d = '0;
                if (accept) begin
                    idx_d = sel_in;
                end
            end
            SCAN: begin
                if (state_q != SCAN) begin
                    idx_d   = '0;
                    dwell_d = '0;
                end else if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    idx_d   = idx_q + 1'b1;
                    wrap_d  = (idx_q == IDX_LAST);
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            default: begin
                idx_d   = idx_q;
                dwell_d = dwell_q;
            end
        endcase
    end

    // Decode the index that will be held next cycle; blank the lines when going idle.
    onehot_dec #(
        .SEL_W (SEL_W)
    ) u_dec (
        .en_i  (state_d != IDLE),
        .sel_i (idx_d),
        .y_o   (dec_y)
    );

    // Controller state and all registered outputs; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            dwell_q   <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            dwell_q   <= dwell_d;
            y_q       <= dec_y;
            y_valid_q <= (state_d != IDLE);
            wrap_q    <= wrap_d;
        end
    end

    assign y         = y_q;
    assign y_valid   = y_valid_q;
    assign scan_wrap = wrap_q;

endmodule

// File: tb/tb_decoder_scan.sv
// Directed testbench for decoder_scan: a vector table for DIRECT/IDLE/SCAN behaviour
// on a SEL_W=2, DWELL=3 instance, plus a hand sequence for reset mid-scan on a
// SEL_W=3, DWELL=1 instance.
module tb_decoder_scan;

    logic clk = 1'b0;

    // Free-running 10 ns clock shared by both instances.
    always #5 clk = ~clk;

    // Instance A: SEL_W=2, DWELL=3
    logic       rstA, enA, modeA, validA;
    logic [1:0] selA;
    logic       readyA, yvA, wrapA;
    logic [3:0] yA;

    // Instance B: SEL_W=3, DWELL=1
    logic       rstB, enB, modeB, validB;
    logic [2:0] selB;
    logic       readyB, yvB, wrapB;
    logic [7:0] yB;

    decoder_scan #(.SEL_W(2), .DWELL(3)) dutA (
        .clk       (clk),
        .rst       (rstA),
        .enable    (enA),
        .mode      (modeA),
        .sel_in    (selA),
        .sel_valid (validA),
        .sel_ready (readyA),
        .y         (yA),
        .y_valid   (yvA),
        .scan_wrap (wrapA)
    );

    decoder_scan #(.SEL_W(3), .DWELL(1)) dutB (
        .clk       (clk),
        .rst       (rstB),
        .enable    (enB),
        .mode      (modeB),
        .sel_in    (selB),
        .sel_valid (validB),
        .sel_ready (readyB),
        .y         (yB),
        .y_valid   (yvB),
        .scan_wrap (wrapB)
    );

    int testsRun    = 0;
    int testsFailed = 0;

    // Inputs for one cycle; expReady is checked before the edge, the rest after it.
    typedef struct {
        logic       en;
        logic       md;
        logic [1:0] sel;
        logic       vld;
        logic       expReady;
        logic [3:0] expY;
        logic       expYv;
        logic       expWrap;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input logic en, input logic md, input logic [1:0] sel,
                          input logic vld, input logic expReady, input logic [3:0] expY,
                          input logic expYv, input logic expWrap);
        vec_t v;
        v.en = en; v.md = md; v.sel = sel; v.vld = vld;
        v.expReady = expReady; v.expY = expY; v.expYv = expYv; v.expWrap = expWrap;
        vecs.push_back(v);
    endtask

    task automatic checkOutput(input string name, input int idx,
                               input logic [7:0] act, input logic [7:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        enA    = v.en;
        modeA  = v.md;
        selA   = v.sel;
        validA = v.vld;
    endtask

    initial begin
        rstA = 1'b1; enA = 1'b0; modeA = 1'b0; selA = '0; validA = 1'b0;
        rstB = 1'b1; enB = 1'b0; modeB = 1'b0; selB = '0; validB = 1'b0;

        // Vector table for instance A.
        // DIRECT: entry shows idx 0, then accepts 2, 0, 3, then holds
        addVec(1, 0, 2'd0, 0, 0, 4'b0001, 1, 0);
        addVec(1, 0, 2'd2, 1, 1, 4'b0100, 1, 0);
        addVec(1, 0, 2'd0, 1, 1, 4'b0001, 1, 0);
        addVec(1, 0, 2'd3, 1, 1, 4'b1000, 1, 0);
        addVec(1, 0, 2'd1, 0, 1, 4'b1000, 1, 0);
        // Disable for 3 cycles (first one with a pending valid), then restore
        addVec(0, 0, 2'd2, 1, 0, 4'b0000, 0, 0);
        addVec(0, 0, 2'd2, 0, 0, 4'b0000, 0, 0);
        addVec(0, 0, 2'd2, 0, 0, 4'b0000, 0, 0);
        addVec(1, 0, 2'd0, 0, 0, 4'b1000, 1, 0);
        addVec(1, 0, 2'd0, 0, 1, 4'b1000, 1, 0);
        // SCAN with DWELL=3, entered with a pending valid that must be ignored
        addVec(1, 1, 2'd1, 1, 0, 4'b0001, 1, 0);
        addVec(1, 1, 2'd0, 0, 0, 4'b0001, 1, 0);
        addVec(1, 1, 2'd0, 0, 0, 4'b0001, 1, 0);
        addVec(1, 1, 2'd0, 0, 0, 4'b0010, 1, 0);
        addVec(1, 1, 2'd3, 1, 0, 4'b0010, 1, 0);
        addVec(1, 1, 2'd0, 0, 0, 4'b0010, 1, 0);
        addVec(1, 1, 2'd0, 0, 0, 4'b0100, 1, 0);
        addVec(1, 1, 2'd0, 0, 0, 4'b0100, 1, 0);
        addVec(1, 1, 2'd0, 0, 0, 4'b0100, 1, 0);
        addVec(1, 1, 2'd0, 0, 0, 4'b1000, 1, 0);
        addVec(1, 1, 2'd0, 0, 0, 4'b1000, 1, 0);
        addVec(1, 1, 2'd0, 0, 0, 4'b1000, 1, 0);
        addVec(1, 1, 2'd0, 0, 0, 4'b0001, 1, 1);
        addVec(1, 1, 2'd0, 0, 0, 4'b0001, 1, 0);
        addVec(1, 1, 2'd0, 0, 0, 4'b0001, 1, 0);
        addVec(1, 1, 2'd0, 0, 0, 4'b0010, 1, 0);
        addVec(1, 1, 2'd0, 0, 0, 4'b0010, 1, 0);
        addVec(1, 1, 2'd0, 0, 0, 4'b0010, 1, 0);
        addVec(1, 1, 2'd0, 0, 0, 4'b0100, 1, 0);
        // Switch to DIRECT at idx 2 with valid on the switch cycle: ignored
        addVec(1, 0, 2'd1, 1, 0, 4'b0100, 1, 0);
        addVec(1, 0, 2'd3, 0, 1, 4'b0100, 1, 0);
        addVec(1, 0, 2'd1, 1, 1, 4'b0010, 1, 0);

        // Reset both instances for 2 cycles, release with enable low
        repeat (2) @(posedge clk);
        #1;
        rstA = 1'b0;
        rstB = 1'b0;
        #1;
        checkOutput("rst_ready", 0, {7'b0, readyA}, 8'd0);
        @(posedge clk);
        #1;
        checkOutput("rst_y",     0, {4'b0, yA},     8'd0);
        checkOutput("rst_yv",    0, {7'b0, yvA},    8'd0);
        checkOutput("rst_ready", 1, {7'b0, readyA}, 8'd0);
        checkOutput("rst_wrap",  0, {7'b0, wrapA},  8'd0);
        checkOutput("rstB_y",    0, yB,             8'd0);

        // Table-driven run on instance A
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput("ready", i, {7'b0, readyA}, {7'b0, vecs[i].expReady});
            @(posedge clk);
            #1;
            checkOutput("y",    i, {4'b0, yA},    {4'b0, vecs[i].expY});
            checkOutput("yv",   i, {7'b0, yvA},   {7'b0, vecs[i].expYv});
            checkOutput("wrap", i, {7'b0, wrapA}, {7'b0, vecs[i].expWrap});
        end
        enA = 1'b0;

        // Instance B: SCAN with DWELL=1, reset pulsed at idx 5
        enB = 1'b1; modeB = 1'b1; selB = 3'd6; validB = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("B_entry_y", 0, yB, 8'b0000_0001);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            checkOutput("B_pre_y", k, yB, 8'd1 << k);
            checkOutput("B_ready", k, {7'b0, readyB}, 8'd0);
        end
        rstB = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("B_rst_y",    0, yB,             8'd0);
        checkOutput("B_rst_yv",   0, {7'b0, yvB},    8'd0);
        checkOutput("B_rst_wrap", 0, {7'b0, wrapB},  8'd0);
        rstB = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("B_restart_y",    0, yB,            8'b0000_0001);
        checkOutput("B_restart_wrap", 0, {7'b0, wrapB}, 8'd0);
        for (int k = 1; k <= 16; k++) begin
            logic [7:0] expY;
            logic       expWrap;
            expY    = 8'd1 << (k % 8);
            expWrap = ((k % 8) == 0);
            @(posedge clk);
            #1;
            checkOutput("B_scan_y",    k, yB,            expY);
            checkOutput("B_scan_yv",   k, {7'b0, yvB},   8'd1);
            checkOutput("B_scan_wrap", k, {7'b0, wrapB}, {7'b0, expWrap});
        end
        enB = 1'b0;

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/decoder_scan.md
Name: decoder_scan

Overview:
- Parametrised, registered one-hot decoder: SEL_W-bit index in, 2**SEL_W one-hot lines out, with enable gating.
- Adds two modes. DIRECT decodes handshaked index requests. SCAN auto-cycles through all outputs with a programmable dwell time, for multiplexed displays and row strobes.
- Sits between control logic and per-line enables. All outputs are registered, so there are no decode glitches.

Parameters:
- SEL_W, 2, index width; output count N = 2**SEL_W.
- DWELL, 4, cycles each output stays active in SCAN mode (>=1).
- CNT_W, $clog2(DWELL+1), dwell counter width (derived).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- enable  input  1  global enable; 0 forces outputs inactive
- mode  input  1  0 = DIRECT, 1 = SCAN
- sel_in  input  SEL_W  requested index (DIRECT)
- sel_valid  input  1  sel_in valid
- sel_ready  output  1  block accepts sel_in this cycle
- y  output  N  registered one-hot output
- y_valid  output  1  y holds a live decode
- scan_wrap  output  1  one-cycle pulse when scan index wraps N-1 -> 0

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: y=0, y_valid=0, sel_ready=0, scan_wrap=0; idx=0, dwell_cnt=0; state=IDLE.
- States: IDLE, DIRECT, SCAN. Next state is evaluated every cycle:
  - enable=0 -> IDLE
  - enable=1, mode=0 -> DIRECT
  - enable=1, mode=1 -> SCAN
- IDLE:
  - y=0 and y_valid=0 from the cycle after enable falls.
  - idx and dwell_cnt hold.
  - sel_ready=0.
- DIRECT:
  - sel_ready=1 (combinational: enable & ~mode & state==DIRECT). The first cycle after entering from IDLE/SCAN, sel_ready=0.
  - On sel_valid & sel_ready: idx<=sel_in. Next cycle y = 1<<sel_in and y_valid=1. Latency is 1 cycle; back-to-back accepts are allowed every cycle.
  - With no accept, y holds the last decode. On entry from IDLE with no prior capture, y shows 1<<idx with y_valid=1.
  - dwell_cnt held at 0. scan_wrap=0.
- SCAN:
  - sel_ready=0; sel_in is ignored.
  - On entry, idx<=0 and dwell_cnt<=0. The first scanned output is y[0], valid the cycle after entry.
  - Each cycle dwell_cnt increments. When dwell_cnt==DWELL-1: dwell_cnt<=0 and idx<=idx+1 (mod N).
  - Each output is therefore active exactly DWELL consecutive cycles.
  - When idx wraps N-1 -> 0, scan_wrap=1 for exactly the cycle in which y[0] first reasserts.
  - DWELL=1: index advances every cycle.
- Simultaneous events:
  - enable falling while sel_valid=1: no capture.
  - Mode change with a pending sel_valid: the new mode wins, no capture.
  - rst dominates everything.
- Reset mid-scan: next cycle all outputs are at reset values, and scanning restarts from idx=0 on the next SCAN entry.
- Invariant: y is one-hot when y_valid=1, and all-zero when y_valid=0.
- Arithmetic: idx wraps naturally at SEL_W bits. dwell_cnt compares against DWELL-1 at CNT_W bits.

Decomposition:
- Package decoder_pkg: state enum (IDLE, DIRECT, SCAN) and the MODE_DIRECT/MODE_SCAN constants.
- Sub-module onehot_dec (combinational SEL_W -> N one-hot, with enable input); instantiated once and registered in the parent.
- FSM, dwell counter and handshake stay in decoder_scan.

Test Plan:
1. rst=1 for 2 cycles, then release with enable=0 -> y=0, y_valid=0, sel_ready=0, scan_wrap=0.
2. SEL_W=2, enable=1, mode=0: sel_in=2 with sel_valid=1, then 0, then 3 on consecutive cycles -> y = 4'b0100, 4'b0001, 4'b1000 on the following cycles; sel_ready=1 throughout after entry.
3. SCAN with DWELL=3, SEL_W=2 -> y cycles 0001x3, 0010x3, 0100x3, 1000x3, then 0001; scan_wrap=1 only on the first cycle of each returning 0001.
4. SCAN running at idx=2, then mode=0 with sel_valid=1, sel_in=1 on the switch cycle -> sel_in ignored; in DIRECT, y holds 0100 until a later accept of sel_in=1 gives 0010.
5. DIRECT at y=1000, drop enable for 3 cycles, then restore -> y=0 and y_valid=0 while disabled; on re-entry y=1000 and y_valid=1 again.
6. SEL_W=3, DWELL=1, SCAN with rst pulsed at idx=5 -> next cycle outputs are at reset values; scan resumes from y[0]; 8 outputs each one cycle, with scan_wrap every 8 cycles.
